// File: rtl/audio_mem_pkg.sv
// Shared constants and state type for the voice record/playback path.
package audio_mem_pkg;

  localparam int MEM_ADDR_W     = 10;
  localparam int MEM_DEPTH      = 1024;
  localparam int MEM_SAMPLE_DIV = 3125;  // 50 MHz / 16 kHz

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_e;

endpackage

// File: rtl/record_play_sequencer_if.sv
// Control and address bundle between the record/play sequencer and its user.
interface record_play_sequencer_if
  import audio_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
);

  logic              start_record;
  logic              start_play;
  logic              stop;
  logic              flag_record;
  logic              flag_play;
  logic [ADDR_W-1:0] write_address;
  logic [ADDR_W-1:0] read_address;
  logic              mem_we;
  logic              sample_strobe;
  logic [ADDR_W:0]   msg_len;

  modport master (
    output start_record, start_play, stop,
    input  flag_record, flag_play, write_address, read_address,
           mem_we, sample_strobe, msg_len
  );

  modport slave (
    input  start_record, start_play, stop,
    output flag_record, flag_play, write_address, read_address,
           mem_we, sample_strobe, msg_len
  );

endinterface

// File: rtl/sample_tick_gen.sv
// Sample-period divider: counts 0..SAMPLE_DIV-1, then one strobe cycle, then wraps.
// tick is high while the count sits at SAMPLE_DIV-1, so a registered strobe follows it.
module sample_tick_gen
  import audio_mem_pkg::*;
#(
  parameter int SAMPLE_DIV = MEM_SAMPLE_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(SAMPLE_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_TICK   = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_STROBE = CNT_W'(SAMPLE_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clear || cnt_q == CNT_STROBE) cnt_d = '0;
    else                              cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_TICK);

endmodule

// File: rtl/record_play_sequencer.sv
// Record/playback control FSM driving the memory address mux, write strobe and DAC strobe.
// Define LOOP_PLAY_EN to make playback wrap to address 0 until stop instead of one-shot.
module record_play_sequencer
  import audio_mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int SAMPLE_DIV = MEM_SAMPLE_DIV
) (
  input logic                    clk,
  input logic                    rst_n,
  record_play_sequencer_if.slave bus
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  state_e            state_q, state_d;
  logic              flag_record_q, flag_record_d;
  logic              flag_play_q, flag_play_d;
  logic [ADDR_W-1:0] write_address_q, write_address_d;
  logic [ADDR_W-1:0] read_address_q, read_address_d;
  logic              mem_we_q, mem_we_d;
  logic              sample_strobe_q, sample_strobe_d;
  logic [LEN_W-1:0]  msg_len_q, msg_len_d;
  logic              tick_clear;
  logic              tick;
  logic              last_sample;

  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(tick_clear),
    .tick (tick)
  );

  assign last_sample = ({1'b0, read_address_q} == (msg_len_q - LEN_ONE));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d         = state_q;
    write_address_d = write_address_q;
    read_address_d  = read_address_q;
    msg_len_d       = msg_len_q;
    mem_we_d        = 1'b0;
    sample_strobe_d = 1'b0;
    tick_clear      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_record) begin
          state_d         = RECORD;
          write_address_d = '0;
          msg_len_d       = '0;
          tick_clear      = 1'b1;
        end else if (bus.start_play && msg_len_q != '0) begin
          state_d        = PLAY;
          read_address_d = '0;
          tick_clear     = 1'b1;
        end
      end

      RECORD: begin
        // A write in flight always completes, even when stop arrives with it.
        if (mem_we_q) begin
          msg_len_d = msg_len_q + LEN_ONE;
          if (write_address_q == LAST_ADDR) state_d = IDLE;
          else                              write_address_d = write_address_q + ADDR_ONE;
        end
        if (bus.stop)                          state_d  = IDLE;
        else if (tick && state_d == RECORD)    mem_we_d = 1'b1;
      end

      PLAY: begin
        if (sample_strobe_q) begin
          if (last_sample) begin
`ifdef LOOP_PLAY_EN
            read_address_d = '0;
`else
            state_d = IDLE;
`endif
          end else begin
            read_address_d = read_address_q + ADDR_ONE;
          end
        end
        if (bus.stop)                       state_d         = IDLE;
        else if (tick && state_d == PLAY)   sample_strobe_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    flag_record_d = (state_d == RECORD);
    flag_play_d   = (state_d == PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      flag_record_q   <= 1'b0;
      flag_play_q     <= 1'b0;
      write_address_q <= '0;
      read_address_q  <= '0;
      mem_we_q        <= 1'b0;
      sample_strobe_q <= 1'b0;
      msg_len_q       <= '0;
    end else begin
      state_q         <= state_d;
      flag_record_q   <= flag_record_d;
      flag_play_q     <= flag_play_d;
      write_address_q <= write_address_d;
      read_address_q  <= read_address_d;
      mem_we_q        <= mem_we_d;
      sample_strobe_q <= sample_strobe_d;
      msg_len_q       <= msg_len_d;
    end
  end

  assign bus.flag_record   = flag_record_q;
  assign bus.flag_play     = flag_play_q;
  assign bus.write_address = write_address_q;
  assign bus.read_address  = read_address_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.sample_strobe = sample_strobe_q;
  assign bus.msg_len       = msg_len_q;

endmodule

// File: tb/tb_record_play_sequencer.sv
// Scoreboard bench for record_play_sequencer: stimulus pushes expected strobes, a monitor pops them.
module tb_record_play_sequencer;

  localparam int ADDR_W     = 3;
  localparam int DEPTH      = 8;
  localparam int SAMPLE_DIV = 4;
  localparam int P          = SAMPLE_DIV + 1;  // cycles between successive strobes

  typedef struct {
    bit is_play;
    int addr;
    int cyc;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   model_len = 0;
  ev_t  exp_q[$];

  record_play_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  record_play_sequencer #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      ev_t ev;
      check("flags_exclusive", int'(bus.flag_record & bus.flag_play), 0);
      if (bus.mem_we || bus.sample_strobe) begin
        check("strobe_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          ev = exp_q.pop_front();
          check("strobe_kind", int'(bus.sample_strobe), int'(ev.is_play));
          check("strobe_single", int'(bus.mem_we & bus.sample_strobe), 0);
          check("strobe_cycle", cyc, ev.cyc);
          check("strobe_addr", ev.is_play ? int'(bus.read_address) : int'(bus.write_address),
                ev.addr);
          check("strobe_flag", ev.is_play ? int'(bus.flag_play) : int'(bus.flag_record), 1);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic drive_idle();
    bus.start_record = 1'b0;
    bus.start_play   = 1'b0;
    bus.stop         = 1'b0;
  endtask

  // t0 is the cycle in which the start pulse is presented.
  task automatic pulse_start(input bit rec, input bit ply, output int t0);
    @(negedge clk);
    bus.start_record = rec;
    bus.start_play   = ply;
    t0 = cyc;
    @(negedge clk);
    bus.start_record = 1'b0;
    bus.start_play   = 1'b0;
  endtask

  // Runs until the first IDLE cycle; optional stray start pulses must be ignored.
  task automatic run_until(input int idle_cyc, input int stop_cyc, input bit noise);
    while (cyc < idle_cyc) begin
      bus.stop         = (cyc == stop_cyc);
      bus.start_record = noise && ($urandom_range(0, 5) == 0);
      bus.start_play   = noise && ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flag_record"}, int'(bus.flag_record), 0);
    check({tag, "_flag_play"}, int'(bus.flag_play), 0);
    check({tag, "_write_address"}, int'(bus.write_address), 0);
    check({tag, "_read_address"}, int'(bus.read_address), 0);
    check({tag, "_mem_we"}, int'(bus.mem_we), 0);
    check({tag, "_sample_strobe"}, int'(bus.sample_strobe), 0);
    check({tag, "_msg_len"}, int'(bus.msg_len), 0);
  endtask

  // n_stop: stop after that many writes (0 = never); off: cycles after that write.
  task automatic do_record(input int n_stop, input int off, input bit both, input bit noise);
    int t0, n_wr, stop_cyc, idle_cyc;
    pulse_start(1'b1, both, t0);
    check("rec_entry_flag", int'(bus.flag_record), 1);
    check("rec_entry_play", int'(bus.flag_play), 0);
    check("rec_entry_waddr", int'(bus.write_address), 0);
    check("rec_entry_len", int'(bus.msg_len), 0);
    n_wr = (n_stop == 0 || n_stop > DEPTH) ? DEPTH : n_stop;
    for (int k = 0; k < n_wr; k++)
      exp_q.push_back('{is_play: 1'b0, addr: k, cyc: t0 + P * (k + 1)});
    stop_cyc = (n_stop == 0) ? -1 : t0 + P * n_stop + off;
    idle_cyc = t0 + P * DEPTH + 1;
    if (n_stop != 0 && stop_cyc + 1 < idle_cyc) idle_cyc = stop_cyc + 1;
    run_until(idle_cyc, stop_cyc, noise);
    model_len = n_wr;
    check("rec_done_flag", int'(bus.flag_record), 0);
    check("rec_done_len", int'(bus.msg_len), model_len);
    check("rec_done_waddr", int'(bus.write_address), (n_wr == DEPTH) ? DEPTH - 1 : n_wr);
    check("rec_drain", exp_q.size(), 0);
  endtask

  // m_stop: stop after that many strobes (0 = let it run to its natural end).
  task automatic do_play(input int m_stop, input int off, input bit noise);
    int  t0, n_st, stop_cyc, idle_cyc;
    int  len;
    bit  natural_end;
    len         = model_len;
    natural_end = 1'b0;
    pulse_start(1'b0, 1'b1, t0);
    check("play_entry_flag", int'(bus.flag_play), 1);
    check("play_entry_rec", int'(bus.flag_record), 0);
    check("play_entry_raddr", int'(bus.read_address), 0);
`ifdef LOOP_PLAY_EN
    if (m_stop == 0) m_stop = 2 * len + 1;
    n_st     = m_stop;
    stop_cyc = t0 + P * m_stop + off;
    idle_cyc = stop_cyc + 1;
`else
    n_st        = (m_stop == 0 || m_stop > len) ? len : m_stop;
    natural_end = (n_st == len);
    stop_cyc    = (m_stop == 0) ? -1 : t0 + P * m_stop + off;
    idle_cyc    = t0 + P * len + 1;
    if (m_stop != 0 && stop_cyc + 1 < idle_cyc) idle_cyc = stop_cyc + 1;
`endif
    for (int k = 0; k < n_st; k++)
      exp_q.push_back('{is_play: 1'b1, addr: k % len, cyc: t0 + P * (k + 1)});
    run_until(idle_cyc, stop_cyc, noise);
    check("play_done_flag", int'(bus.flag_play), 0);
    check("play_done_len", int'(bus.msg_len), len);
    if (natural_end)   check("play_done_raddr", int'(bus.read_address), len - 1);
    else if (off != 0) check("play_stop_raddr", int'(bus.read_address), n_st % len);
    check("play_drain", exp_q.size(), 0);
  endtask

  task automatic do_empty_play();
    int t0;
    pulse_start(1'b0, 1'b1, t0);
    check("empty_play_flag", int'(bus.flag_play), 0);
    repeat (P + 2) @(negedge clk);
    check("empty_play_flag_late", int'(bus.flag_play), 0);
    check("empty_play_len", int'(bus.msg_len), 0);
  endtask

  task automatic do_play_reset();
    int t0, r, len;
    len = model_len;
    pulse_start(1'b0, 1'b1, t0);
    for (int k = 0; k < 2 * len; k++)
      exp_q.push_back('{is_play: 1'b1, addr: k % len, cyc: t0 + P * (k + 1)});
    r = $urandom_range(1, P * len - 1);
    repeat (r) @(negedge clk);
    check("pre_reset_flag_play", int'(bus.flag_play), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    model_len = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_flag_rec", int'(bus.flag_record), 0);
    check("post_reset_flag_play", int'(bus.flag_play), 0);
    check("post_reset_len", int'(bus.msg_len), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_empty_play();
    do_record(3, 2, 1'b0, 1'b0);
`ifdef LOOP_PLAY_EN
    do_play(5, 1, 1'b0);
`else
    do_play(0, 0, 1'b0);
`endif
    do_record(0, 0, 1'b0, 1'b1);
    do_play(0, 0, 1'b1);
    do_record($urandom_range(1, DEPTH - 1), 0, 1'b0, 1'b0);
    do_record(2, 3, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 0 || model_len == 0)
        do_record($urandom_range(1, DEPTH + 1), $urandom_range(0, 4),
                  1'($urandom_range(0, 1)), 1'b1);
      else
        do_play($urandom_range(0, DEPTH + 2), $urandom_range(0, 4), 1'b1);
    end

    do_record($urandom_range(2, DEPTH - 1), 1, 1'b0, 1'b0);
    do_play_reset();
    do_empty_play();

    check("final_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
